// File: rtl/booth_r4_mult_seq_if.sv
// Operand/result bundle for booth_r4_mult_seq.
//   start        : request, sampled only while the multiplier is idle
//   multiplicand : operand M, captured on the accepted start
//   multiplier   : operand Q, captured on the accepted start
//   tc           : 1 = signed, 0 = unsigned (only with BOOTH_UNSIGNED_EN)
//   busy         : high while an operation is in flight (RUN and DONE)
//   done         : one-cycle pulse, product valid
//   product      : result register, held until the next done
// master modport = operand source, slave modport = multiplier.
interface booth_r4_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
`ifdef BOOTH_UNSIGNED_EN
    logic                 tc;
`endif
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
`ifdef BOOTH_UNSIGNED_EN
        output tc,
`endif
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
`ifdef BOOTH_UNSIGNED_EN
        input  tc,
`endif
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier, one Booth digit per clock, one operation in flight.
// Optional macro BOOTH_UNSIGNED_EN adds the tc input (1 = signed, 0 = unsigned); without it
// operands are always two's-complement signed.
// Ports:
//   clk    : system clock, all state updates on posedge
//   rst    : asynchronous active-low reset; aborts any operation without a done
//   bus_io : slave side of booth_r4_mult_seq_if (start/operands in, busy/done/product out)
module booth_r4_mult_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH / 2 + 2)
) (
    input logic                clk,
    input logic                rst,
    booth_r4_mult_seq_if.slave bus_io
);
    localparam int unsigned AW = WIDTH + 2;  // two guard bits absorb +/-2M without overflow
    localparam logic [CNT_W-1:0] NSigned   = CNT_W'(WIDTH / 2);
    localparam logic [CNT_W-1:0] NUnsigned = CNT_W'(WIDTH / 2 + 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [AW-1:0]        m_q, m_d;
    logic [AW-1:0]        q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 cap_signed;  // mode presented with start
    logic                 run_signed;  // mode of the operation in flight
    logic [AW-1:0]        addend;
    logic [AW-1:0]        acc_sum;
    logic [AW-1:0]        acc_shift;
    logic [AW-1:0]        q_shift;

`ifdef BOOTH_UNSIGNED_EN
    logic signed_q, signed_d;
    assign cap_signed = bus_io.tc;
    assign run_signed = signed_q;
`else
    assign cap_signed = 1'b1;
    assign run_signed = 1'b1;
`endif

    // Booth digit from {Q[1], Q[0], q_1}; negation is invert plus carry-in.
    always_comb begin
        addend = '0;
        case ({q_q[1:0], q1_q})
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = m_q << 1;
            3'b100:         addend = ~(m_q << 1) + AW'(1);
            3'b101, 3'b110: addend = ~m_q + AW'(1);
            default:        addend = '0;
        endcase
    end

    assign acc_sum   = acc_q + addend;
    // Arithmetic shift right by two across {acc, Q}.
    assign acc_shift = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
    assign q_shift   = {acc_sum[1:0], q_q[AW-1:2]};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef BOOTH_UNSIGNED_EN
        signed_d  = signed_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    m_d   = cap_signed ? {{2{bus_io.multiplicand[WIDTH-1]}}, bus_io.multiplicand}
                                       : {2'b00, bus_io.multiplicand};
                    q_d   = cap_signed ? {{2{bus_io.multiplier[WIDTH-1]}}, bus_io.multiplier}
                                       : {2'b00, bus_io.multiplier};
                    acc_d = '0;
                    q1_d  = 1'b0;
                    cnt_d = cap_signed ? NSigned : NUnsigned;
`ifdef BOOTH_UNSIGNED_EN
                    signed_d = cap_signed;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_shift;
                q_d   = q_shift;
                q1_d  = q_q[1];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Signed: WIDTH bits shifted out, low half sits in Q[AW-1:2].
                    // Unsigned: WIDTH+2 bits shifted out, low half spans all of Q.
                    product_d = run_signed ? {acc_shift[WIDTH-1:0], q_shift[AW-1:2]}
                                           : {acc_shift[WIDTH-3:0], q_shift};
                    state_d   = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef BOOTH_UNSIGNED_EN
            signed_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef BOOTH_UNSIGNED_EN
            signed_q  <= signed_d;
`endif
        end
    end

    assign bus_io.busy    = (state_q != StIdle);
    assign bus_io.done    = (state_q == StDone);
    assign bus_io.product = product_q;

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// Bench for booth_r4_mult_seq (WIDTH=8): cycle-by-cycle comparison of busy/done/product against
// a timing/arithmetic model, plus literal product and latency checks on directed operations.
module tb_booth_r4_mult_seq;
    localparam int W = 8;

    logic clk;
    logic rst;
    logic tc_v;

    booth_r4_mult_seq_if #(.WIDTH(W)) bus ();

`ifdef BOOTH_UNSIGNED_EN
    assign bus.tc = tc_v;
`endif

    booth_r4_mult_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mode_signed();
`ifdef BOOTH_UNSIGNED_EN
        return tc_v;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input bit sgn);
        longint x, y, p;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        p = x * y;
        return p[2*W-1:0];
    endfunction

    // Model: an accepted start at edge t0 means busy after edges t0..t0+N, done after edge
    // t0+N with the product loaded then; the block is idle again after edge t0+N+1.
    int               cyc      = 0;
    bit               m_active = 1'b0;
    int               t_start  = 0;
    int               t_done   = 0;
    logic [2*W-1:0]   m_pend   = '0;
    logic [2*W-1:0]   exp_product = '0;
    logic             exp_busy = 1'b0;
    logic             exp_done = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_active    = 1'b0;
                exp_busy    = 1'b0;
                exp_done    = 1'b0;
                exp_product = '0;
            end else begin
                cyc++;
                if ((!m_active || (cyc - 1 > t_done)) && bus.start === 1'b1) begin
                    m_active = 1'b1;
                    t_start  = cyc;
                    t_done   = cyc + (mode_signed() ? W / 2 : W / 2 + 1);
                    m_pend   = ref_mul(bus.multiplicand, bus.multiplier, mode_signed());
                end
                exp_busy = m_active && (cyc >= t_start) && (cyc <= t_done);
                exp_done = m_active && (cyc == t_done);
                if (exp_done) exp_product = m_pend;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("busy", longint'(bus.busy), longint'(exp_busy));
            check("done", longint'(bus.done), longint'(exp_done));
            check("product", longint'(bus.product), longint'(exp_product));
        end
    end

    // Bounded wait for done; k counts negedges from the start-sampling edge (k=1 right after it).
    task automatic wait_done(input string name, input int exp_k, input logic [2*W-1:0] lit);
        int k;
        k = 1;
        while (bus.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (bus.done !== 1'b1) begin
            check({name, " done timeout"}, 0, 1);
        end else begin
            check({name, " latency"}, k, exp_k);
            check({name, " product"}, longint'(bus.product), longint'(lit));
        end
    endtask

    task automatic do_op(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                         input bit sgn, input logic [2*W-1:0] lit);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
        tc_v             = sgn;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(name, (sgn ? W / 2 : W / 2 + 1) + 1, lit);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 8'h80;
            1:       v = 8'h7F;
            2:       v = 8'hFF;
            3:       v = 8'h00;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        rst              = 1'b0;
        tc_v             = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle product", longint'(bus.product), 0);
            check("idle busy", longint'(bus.busy), 0);
        end

        do_op("68x35", 8'd68, 8'd35, 1'b1, 16'h094C);
        do_op("min x min", 8'h80, 8'h80, 1'b1, 16'h4000);
        do_op("min x max", 8'h80, 8'h7F, 1'b1, 16'hC080);
        do_op("0 x -1", 8'h00, 8'hFF, 1'b1, 16'h0000);

        // start re-pulsed during RUN must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 8'd68; bus.multiplier = 8'd35; tc_v = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 8'd3; bus.multiplier = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("repulse", 4 + 1 - 2, 16'h094C);
        repeat (5) @(negedge clk);
        check("repulse hold", longint'(bus.product), 16'h094C);

        // reset dropped on the second RUN cycle aborts the operation
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 8'd68; bus.multiplier = 8'd35;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("abort busy", longint'(bus.busy), 0);
        check("abort done", longint'(bus.done), 0);
        check("abort product", longint'(bus.product), 0);
        #2 rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort no done", longint'(bus.done), 0);
        end
        do_op("5x-3", 8'd5, 8'hFD, 1'b1, 16'hFFF1);

        // start held high: back-to-back operations every N+2 cycles
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 8'd100; bus.multiplier = 8'h9C;
        repeat (20) @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);

        // randomized traffic, checked every cycle against the model
        for (int i = 0; i < 400; i++) begin
            bus.start        = ($urandom_range(0, 3) != 0);
            bus.multiplicand = pick_operand();
            bus.multiplier   = pick_operand();
`ifdef BOOTH_UNSIGNED_EN
            tc_v = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (8) @(negedge clk);

`ifdef BOOTH_UNSIGNED_EN
        do_op("u 255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        do_op("u 128x200", 8'h80, 8'hC8, 1'b0, 16'h6400);
        do_op("s 255x255", 8'hFF, 8'hFF, 1'b1, 16'h0001);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
